// File: rtl/riscv_pkg.sv
// Shared constants for the multi-cycle RV32I control unit: opcodes, ALU codes,
// mux encodings, FSM states and the opcode/funct3 legality check.
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_XOR    = 4'd2;
   localparam logic [3:0] ALU_OR     = 4'd3;
   localparam logic [3:0] ALU_AND    = 4'd4;
   localparam logic [3:0] ALU_SLL    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_SLT    = 4'd8;
   localparam logic [3:0] ALU_SLTU   = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;
   localparam logic [3:0] ALU_PC_B   = 4'd11;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam logic [1:0] RES_ALUOUT = 2'd0;
   localparam logic [1:0] RES_RDATA  = 2'd1;
   localparam logic [1:0] RES_PC4    = 2'd2;
   localparam logic [1:0] RES_ALURES = 2'd3;

   localparam logic [1:0] SRCB_REG  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXER, EXEI,
      ALUWB, BRANCH, JAL, JALR, UPPER, TRAP
   } state_e;

   // Which family of ALU decode applies in the current state.
   typedef enum logic [2:0] {
      CLS_ADD, CLS_OP, CLS_OPIMM, CLS_BRANCH, CLS_UPPER, CLS_PCB
   } alu_class_e;

   // funct3 legality for opcodes that reserve some funct3 values.
   function automatic logic funct3_ok(input logic [6:0] opcode, input logic [2:0] funct3);
      logic ok;
      ok = 1'b1;
      case (opcode)
         OP_LOAD:   ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
         OP_STORE:  ok = (funct3[2] == 1'b0) && (funct3 != 3'b011);
         OP_BRANCH: ok = (funct3 != 3'b010) && (funct3 != 3'b011);
         OP_JALR:   ok = (funct3 == 3'b000);
         default:   ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU operation decode from the state class and instruction fields.
module riscv_alu_decoder
   import riscv_pkg::*;
(
   input  alu_class_e  alu_class,
   input  logic [2:0]  funct3,
   input  logic        funct7_b5,
   input  logic        op_b5,
   output logic [3:0]  alu_control,
   output logic        imm
);

   // Map class + funct fields to an ALU code; Imm flags immediate-form shifts.
   always_comb begin
      alu_control = ALU_ADD;
      imm         = 1'b0;
      case (alu_class)
         CLS_OP, CLS_OPIMM: begin
            case (funct3)
               3'b000:  alu_control = (alu_class == CLS_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = funct7_b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
            imm = (alu_class == CLS_OPIMM) && (funct3[1:0] == 2'b01);
         end
         CLS_BRANCH: begin
            case (funct3[2:1])
               2'b10:   alu_control = ALU_SLT;
               2'b11:   alu_control = ALU_SLTU;
               default: alu_control = ALU_SUB;
            endcase
         end
         CLS_UPPER: alu_control = op_b5 ? ALU_PASS_B : ALU_PC_B;
         CLS_PCB:   alu_control = ALU_PC_B;
         default:   alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I control unit: instruction sequencing FSM plus Moore
// decode of datapath controls from state and the latched instruction.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR, PC <= PC+4
// DECODE | dispatch on opcode (and funct3 legality)
// MEMADR | A + ImmExt address for load/store
// MEMRD  | read data memory at ALUOut
// MEMWB  | write read data to rd
// MEMWR  | write register B to memory at ALUOut
// EXER   | register-register ALU op
// EXEI   | register-immediate ALU op
// ALUWB  | write ALUOut to rd
// BRANCH | compare, load PC target when taken
// JAL    | rd <= PC+4, PC <= PC+ImmJ
// JALR   | rd <= PC+4, PC <= A+ImmI
// UPPER  | LUI / AUIPC result
// TRAP   | unsupported instruction, held until reset
module riscv_mc_controller
   import riscv_pkg::*;
#(
   parameter state_e RESET_STATE = FETCH
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [31:0] Instr,
   input  logic        Zero,
   input  logic        Lt,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic        ALUSrc_A,
   output logic [1:0]  ALUSrcB,
   output logic        Imm,
   output logic [3:0]  ALUControl,
   output logic [2:0]  ImmSrc,
   output logic        Illegal
);

   state_e     state;
   alu_class_e alu_class;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       br_taken;
   logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c;
   logic       unused_fields;

   assign opcode = Instr[6:0];
   assign funct3 = Instr[14:12];

   // Register numbers and immediates are consumed by the datapath, not here.
   assign unused_fields = ^{Instr[31], Instr[29:15], Instr[11:7]};

   riscv_alu_decoder u_alu_dec (
      .alu_class   (alu_class),
      .funct3      (funct3),
      .funct7_b5   (Instr[30]),
      .op_b5       (Instr[5]),
      .alu_control (ALUControl),
      .imm         (Imm)
   );

   // Branch condition from the ALU flags; unsigned/signed already chosen by ALU op.
   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:         br_taken = Zero;
         3'b001:         br_taken = ~Zero;
         3'b100, 3'b110: br_taken = Lt;
         3'b101, 3'b111: br_taken = ~Lt;
         default:        br_taken = 1'b0;
      endcase
   end

   // Sequencing FSM and sticky illegal flag; Illegal rises as TRAP is entered.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state   <= RESET_STATE;
         Illegal <= 1'b0;
      end else begin
         case (state)
            FETCH:  state <= DECODE;
            DECODE: begin
               if (!funct3_ok(opcode, funct3)) begin
                  state   <= TRAP;
                  Illegal <= 1'b1;
               end else begin
                  case (opcode)
                     OP_LOAD, OP_STORE: state <= MEMADR;
                     OP_OP:             state <= EXER;
                     OP_IMM:            state <= EXEI;
                     OP_BRANCH:         state <= BRANCH;
                     OP_JAL:            state <= JAL;
                     OP_JALR:           state <= JALR;
                     OP_LUI, OP_AUIPC:  state <= UPPER;
                     default: begin
                        state   <= TRAP;
                        Illegal <= 1'b1;
                     end
                  endcase
               end
            end
            MEMADR: state <= opcode[5] ? MEMWR : MEMRD;
            MEMRD:  state <= MEMWB;
            EXER, EXEI, UPPER: state <= ALUWB;
            TRAP:   state <= TRAP;
            default: state <= FETCH;
         endcase
      end
   end

   // Per-state datapath controls; write enables gated separately by Reset.
   always_comb begin
      pc_write_c  = 1'b0;
      ir_write_c  = 1'b0;
      mem_write_c = 1'b0;
      reg_write_c = 1'b0;
      AdrSrc      = 1'b0;
      ResultSrc   = RES_ALUOUT;
      ALUSrc_A    = 1'b0;
      ALUSrcB     = SRCB_REG;
      ImmSrc      = IMM_I;
      alu_class   = CLS_ADD;
      case (state)
         FETCH: begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            ALUSrc_A   = 1'b1;
            ALUSrcB    = SRCB_FOUR;
         end
         MEMADR: begin
            ALUSrcB = SRCB_IMM;
            ImmSrc  = opcode[5] ? IMM_S : IMM_I;
         end
         MEMRD: AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc   = RES_RDATA;
            reg_write_c = 1'b1;
         end
         MEMWR: begin
            AdrSrc      = 1'b1;
            mem_write_c = 1'b1;
         end
         EXER: alu_class = CLS_OP;
         EXEI: begin
            alu_class = CLS_OPIMM;
            ALUSrcB   = SRCB_IMM;
         end
         ALUWB: reg_write_c = 1'b1;
         // Compare uses register operands; the target comes from the separate adder.
         BRANCH: begin
            alu_class = CLS_BRANCH;
            ImmSrc    = IMM_B;
            if (br_taken) begin
               pc_write_c = 1'b1;
               ResultSrc  = RES_ALURES;
            end
         end
         JAL: begin
            alu_class   = CLS_PCB;
            ALUSrc_A    = 1'b1;
            ALUSrcB     = SRCB_IMM;
            ImmSrc      = IMM_J;
            pc_write_c  = 1'b1;
            reg_write_c = 1'b1;
            ResultSrc   = RES_PC4;
         end
         JALR: begin
            ALUSrcB     = SRCB_IMM;
            pc_write_c  = 1'b1;
            reg_write_c = 1'b1;
            ResultSrc   = RES_PC4;
         end
         UPPER: begin
            alu_class = CLS_UPPER;
            ALUSrc_A  = 1'b1;
            ALUSrcB   = SRCB_IMM;
            ImmSrc    = IMM_U;
         end
         default: ;
      endcase
   end

   assign PCWrite  = pc_write_c  & ~Reset;
   assign IRWrite  = ir_write_c  & ~Reset;
   assign MemWrite = mem_write_c & ~Reset;
   assign RegWrite = reg_write_c & ~Reset;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Bench for the multi-cycle controller: directed test-plan instructions, trap and
// reset cases, then random instructions checked against an ISA-level model.
module tb_riscv_mc_controller;

   logic        CLK = 1'b0;
   logic        Reset, Zero, Lt;
   logic [31:0] Instr;
   logic        PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrc_A, Imm, Illegal;
   logic [1:0]  ResultSrc, ALUSrcB;
   logic [3:0]  ALUControl;
   logic [2:0]  ImmSrc;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int cyc;   // cycles FETCH..last state
      int alu;   // ALU code in the third cycle
      int imm;   // Imm flag in the third cycle
      int srcb;  // ALUSrcB in the third cycle, -1 = don't care
      int rw;    // RegWrite pulses
      int rsrc;  // ResultSrc during RegWrite
      int mw;    // MemWrite pulses
      int pw;    // PCWrite pulses
   } exp_t;

   always #5 CLK = ~CLK;

   riscv_mc_controller dut (
      .CLK(CLK), .Reset(Reset), .Instr(Instr), .Zero(Zero), .Lt(Lt),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrc_A(ALUSrc_A), .ALUSrcB(ALUSrcB),
      .Imm(Imm), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .Illegal(Illegal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(int cyc, int alu, int imm, int srcb, int rw, int rsrc, int mw, int pw);
      exp_t e;
      e.cyc = cyc; e.alu = alu; e.imm = imm; e.srcb = srcb;
      e.rw = rw; e.rsrc = rsrc; e.mw = mw; e.pw = pw;
      return e;
   endfunction

   // Called at negedge+1 with the DUT in FETCH; returns likewise at the next FETCH.
   task automatic run_instr(input string tag, input logic [31:0] ins, input exp_t e,
                            input logic z, input logic l);
      int c, rw_n, rw_last, rsrc, mw_n, pw_n, alu3, imm3, srcb3;
      bit back;
      rw_n = 0; rw_last = 0; rsrc = 99; mw_n = 0; pw_n = 0; alu3 = 99; imm3 = 99; srcb3 = 99;
      back = 0;
      check({tag, "_in_fetch"}, IRWrite, 1);
      Zero  = z;
      Lt    = l;
      Instr = 32'h0000007F;  // garbage while fetching; must not matter
      #1;
      c = 1;
      for (int k = 0; k < 12 && !back; k++) begin
         if (RegWrite) begin rw_n++; rw_last = c; rsrc = ResultSrc; end
         mw_n += MemWrite;
         pw_n += PCWrite;
         if (c == 3) begin alu3 = ALUControl; imm3 = Imm; srcb3 = ALUSrcB; end
         if (c == 1) Instr = ins;
         @(posedge CLK);
         @(negedge CLK);
         #1;
         if (IRWrite) back = 1;
         else c++;
      end
      check({tag, "_cycles"}, c, e.cyc);
      check({tag, "_alu"}, alu3, e.alu);
      check({tag, "_imm"}, imm3, e.imm);
      if (e.srcb >= 0) check({tag, "_srcb"}, srcb3, e.srcb);
      check({tag, "_regwrite_n"}, rw_n, e.rw);
      if (e.rw > 0) begin
         check({tag, "_regwrite_cyc"}, rw_last, e.cyc);
         check({tag, "_resultsrc"}, rsrc, e.rsrc);
      end
      check({tag, "_memwrite_n"}, mw_n, e.mw);
      check({tag, "_pcwrite_n"}, pw_n, e.pw);
      check({tag, "_illegal"}, Illegal, 0);
   endtask

   // ISA-level reference: pick an instruction of a given class, encode it, and
   // state what the control unit must do for it.
   task automatic gen(input int kind, output logic [31:0] ins, output exp_t e,
                      input logic z, input logic l);
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] i12;
      logic [19:0] i20;
      int          p;
      int          f3s [6];
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      i12 = 12'($urandom); i20 = 20'($urandom);
      case (kind)
         0: begin  // R-type: add sub sll slt sltu xor srl sra or and
            int rf3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
            int rb5 [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
            int ral [10] = '{0, 1, 5, 8, 9, 2, 6, 7, 3, 4};
            p = $urandom_range(0, 9);
            ins = {1'b0, 1'(rb5[p]), 5'b0, rs2, rs1, 3'(rf3[p]), rd, 7'h33};
            e = mk(4, ral[p], 0, 0, 1, 0, 0, 1);
         end
         1: begin  // I-type: addi slti sltiu xori ori andi slli srli srai
            int if3 [9] = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
            int ial [9] = '{0, 8, 9, 2, 3, 4, 5, 6, 7};
            p = $urandom_range(0, 8);
            if (p >= 6) begin
               ins = {1'b0, (p == 8) ? 1'b1 : 1'b0, 5'b0, rs2, rs1, 3'(if3[p]), rd, 7'h13};
               e = mk(4, ial[p], 1, 1, 1, 0, 0, 1);
            end else begin
               ins = {i12, rs1, 3'(if3[p]), rd, 7'h13};  // bit 30 random: ADDI stays ADD
               e = mk(4, ial[p], 0, 1, 1, 0, 0, 1);
            end
         end
         2: begin  // loads lb lh lw lbu lhu
            int lf3 [5] = '{0, 1, 2, 4, 5};
            p = $urandom_range(0, 4);
            ins = {i12, rs1, 3'(lf3[p]), rd, 7'h03};
            e = mk(5, 0, 0, 1, 1, 1, 0, 1);
         end
         3: begin  // stores sb sh sw
            p = $urandom_range(0, 2);
            ins = {i12[11:5], rs2, rs1, 3'(p), i12[4:0], 7'h23};
            e = mk(4, 0, 0, 1, 0, 0, 1, 1);
         end
         4: begin  // branches
            bit taken;
            int bal [6] = '{1, 1, 8, 8, 9, 9};
            f3s = '{0, 1, 4, 5, 6, 7};
            p = $urandom_range(0, 5);
            case (p)
               0: taken = z;
               1: taken = !z;
               2, 4: taken = l;
               default: taken = !l;
            endcase
            ins = {i12[11:5], rs2, rs1, 3'(f3s[p]), i12[4:0], 7'h63};
            e = mk(3, bal[p], 0, -1, 0, 0, 0, taken ? 2 : 1);
         end
         5: begin ins = {i20, rd, 7'h6F};           e = mk(3, 11, 0, 1, 1, 2, 0, 2); end
         6: begin ins = {i12, rs1, 3'b000, rd, 7'h67}; e = mk(3, 0, 0, 1, 1, 2, 0, 2); end
         7: begin ins = {i20, rd, 7'h37};           e = mk(4, 10, 0, 1, 1, 0, 0, 1); end
         default: begin ins = {i20, rd, 7'h17};     e = mk(4, 11, 0, 1, 1, 0, 0, 1); end
      endcase
   endtask

   initial begin
      logic [31:0] ins;
      exp_t        e;
      logic        z, l;
      int          en_seen, ill_low;

      Reset = 1'b1; Instr = 32'h0; Zero = 1'b0; Lt = 1'b0;
      #1;
      check("rst_pcwrite", PCWrite, 0);
      check("rst_irwrite", IRWrite, 0);
      check("rst_memwrite", MemWrite, 0);
      check("rst_regwrite", RegWrite, 0);
      check("rst_srcb", ALUSrcB, 2);
      check("rst_srca", ALUSrc_A, 1);
      check("rst_alu", ALUControl, 0);
      check("rst_illegal", Illegal, 0);
      repeat (2) @(negedge CLK);
      Reset = 1'b0;
      #1;

      // Test-plan instructions
      run_instr("add",  32'h002081B3, mk(4, 0, 0, 0, 1, 0, 0, 1), 0, 0);
      run_instr("srai", 32'h4032D293, mk(4, 7, 1, 1, 1, 0, 0, 1), 0, 0);
      run_instr("srli", 32'h0032D293, mk(4, 6, 1, 1, 1, 0, 0, 1), 0, 0);
      run_instr("lw",   32'h0020A183, mk(5, 0, 0, 1, 1, 1, 0, 1), 0, 0);
      run_instr("sw",   32'h0030A023, mk(4, 0, 0, 1, 0, 0, 1, 1), 0, 0);
      run_instr("blt_t",  32'h0020C463, mk(3, 8, 0, -1, 0, 0, 0, 2), 0, 1);
      run_instr("blt_nt", 32'h0020C463, mk(3, 8, 0, -1, 0, 0, 0, 1), 0, 0);

      // Unsupported opcode: Illegal rises in TRAP, enables stay low
      Instr = 32'h0000007F;
      @(posedge CLK); @(negedge CLK); #1;
      check("trap_decode_illegal", Illegal, 0);
      @(posedge CLK); @(negedge CLK); #1;
      check("trap_illegal", Illegal, 1);
      en_seen = 0; ill_low = 0;
      for (int k = 0; k < 20; k++) begin
         en_seen += int'(PCWrite) + int'(IRWrite) + int'(MemWrite) + int'(RegWrite);
         ill_low += int'(!Illegal);
         @(negedge CLK); #1;
      end
      check("trap_enables", en_seen, 0);
      check("trap_illegal_held", ill_low, 0);
      #2 Reset = 1'b1;
      #1;
      check("trap_rst_illegal", Illegal, 0);
      check("trap_rst_srcb", ALUSrcB, 2);
      @(negedge CLK); Reset = 1'b0; #1;
      check("trap_rst_fetch", IRWrite, 1);

      // Reset mid-EXER, off the clock edge
      Instr = 32'h002081B3;
      @(posedge CLK); @(negedge CLK); #1;
      @(posedge CLK); @(negedge CLK); #1;
      check("exer_alu", ALUControl, 0);
      check("exer_regwrite", RegWrite, 0);
      #2 Reset = 1'b1;
      #1;
      check("exer_rst_regwrite", RegWrite, 0);
      check("exer_rst_srcb", ALUSrcB, 2);
      check("exer_rst_illegal", Illegal, 0);
      @(posedge CLK); #1;
      check("exer_rst_edge_regwrite", RegWrite, 0);
      @(negedge CLK); Reset = 1'b0; #1;
      check("exer_rst_fetch", IRWrite, 1);

      // Random instruction stream against the ISA-level model
      for (int n = 0; n < 120; n++) begin
         z = 1'($urandom); l = 1'($urandom);
         gen($urandom_range(0, 8), ins, e, z, l);
         run_instr($sformatf("rnd%0d_%08h", n, ins), ins, e, z, l);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
